wf_player: RTL and testbench

//  Read side of the waveform DPBRAM. Once XINTF has loaded a waveform, this

---
 rtl/wf_player.sv | 206 ++++++++++++++++++++
 tb/tb_wf_player.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wf_player.sv
// -----------------------------------------------------------------------------
// wf_player -- waveform DPBRAM playback engine
//
// Plays back a waveform that XINTF has loaded into the DPBRAM. The block reads
// N = min(i_wf_read_cnt, 2**ADDR_W) samples sequentially from address 0. Each
// sample goes to the DSP/DAC path with a one-cycle valid strobe, and
// consecutive samples are spaced by a programmable hold period. One-shot
// playback, loop playback and abort are supported.
//
// Ports
//   i_clk              system clock
//   i_rst              asynchronous active-low reset
//   i_wf_start         play request (level; must drop before a replay)
//   i_wf_abort         forces return to IDLE, highest priority
//   i_wf_loop          wrap to address 0 after the last sample (sampled per wrap)
//   i_wf_read_cnt      samples to play (latched on leaving IDLE)
//   i_wf_period        extra hold cycles between samples (latched on leaving IDLE)
//   o_wf_ram_addr      DPBRAM read address, 0 outside FETCH
//   o_wf_ram_ce        DPBRAM read enable, one pulse per sample
//   i_wf_ram_dout      DPBRAM read data
//   o_wf_sample        current sample, held until the next one
//   o_wf_sample_valid  one-cycle strobe when o_wf_sample updates
//   o_dsp_wf_mode      high while in FETCH or HOLD
//   o_wf_done          high in DONE
//   o_wf_read_data_num samples emitted since start (saturating)
// -----------------------------------------------------------------------------
module wf_player #(
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned RD_LAT = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wf_start,
   input  logic              i_wf_abort,
   input  logic              i_wf_loop,
   input  logic [31:0]       i_wf_read_cnt,
   input  logic [15:0]       i_wf_period,
   output logic [ADDR_W-1:0] o_wf_ram_addr,
   output logic              o_wf_ram_ce,
   input  logic [DATA_W-1:0] i_wf_ram_dout,
   output logic [DATA_W-1:0] o_wf_sample,
   output logic              o_wf_sample_valid,
   output logic              o_dsp_wf_mode,
   output logic              o_wf_done,
   output logic [31:0]       o_wf_read_data_num
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [31:0] DEPTH32 = 32'(1) << ADDR_W;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

   typedef enum logic [1:0] {StIdle, StFetch, StHold, StDone} state_e;

   state_e              state_q, state_d;
   logic                start_q;
   logic [CNT_W-1:0]    n_q, n_d;
   logic [15:0]         period_q, period_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [LAT_W-1:0]    lat_q, lat_d;
   logic [15:0]         hold_q, hold_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                ce_q, ce_d;
   logic [DATA_W-1:0]   sample_q, sample_d;
   logic                valid_q, valid_d;
   logic [31:0]         num_q, num_d;

   logic [CNT_W-1:0]    eff_cnt;
   logic [CNT_W-1:0]    idx_next;

   // Count clipped to RAM depth so playback never runs past the last address.
   assign eff_cnt  = (i_wf_read_cnt > DEPTH32) ? DEPTH32[CNT_W-1:0]
                                               : i_wf_read_cnt[CNT_W-1:0];
   assign idx_next = {1'b0, idx_q} + CNT_W'(1);

   // Start is registered once; the FSM acts on the registered level so the
   // IDLE->FETCH edge (and thus the first CE) lands one clock after sampling.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         start_q <= 1'b0;
      end else begin
         start_q <= i_wf_start;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q  <= StIdle;
         n_q      <= '0;
         period_q <= '0;
         idx_q    <= '0;
         lat_q    <= '0;
         hold_q   <= '0;
         addr_q   <= '0;
         ce_q     <= 1'b0;
         sample_q <= '0;
         valid_q  <= 1'b0;
         num_q    <= '0;
      end else begin
         state_q  <= state_d;
         n_q      <= n_d;
         period_q <= period_d;
         idx_q    <= idx_d;
         lat_q    <= lat_d;
         hold_q   <= hold_d;
         addr_q   <= addr_d;
         ce_q     <= ce_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
         num_q    <= num_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      period_d = period_q;
      idx_d    = idx_q;
      lat_d    = lat_q;
      hold_d   = hold_q;
      addr_d   = '0;
      ce_d     = 1'b0;
      sample_d = sample_q;
      valid_d  = 1'b0;
      num_d    = num_q;

      if (i_wf_abort) begin
         // Anything still in the RAM pipeline is simply never captured.
         state_d = StIdle;
         lat_d   = '0;
         hold_d  = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_q) begin
                  n_d      = eff_cnt;
                  period_d = i_wf_period;
                  idx_d    = '0;
                  if (eff_cnt != '0) begin
                     num_d   = '0;
                     state_d = StFetch;
                     ce_d    = 1'b1;
                     lat_d   = '0;
                  end else begin
                     state_d = StDone;
                  end
               end
            end

            StFetch: begin
               addr_d = addr_q;
               if (lat_q == LAT_LAST) begin
                  sample_d = i_wf_ram_dout;
                  valid_d  = 1'b1;
                  num_d    = (num_q == 32'hFFFF_FFFF) ? num_q : num_q + 32'd1;
                  hold_d   = '0;
                  addr_d   = '0;
                  state_d  = StHold;
               end else begin
                  lat_d = lat_q + LAT_W'(1);
               end
            end

            StHold: begin
               if (hold_q == period_q) begin
                  if (idx_next < n_q) begin
                     idx_d   = idx_next[ADDR_W-1:0];
                     state_d = StFetch;
                  end else if (i_wf_loop) begin
                     idx_d   = '0;
                     state_d = StFetch;
                  end else begin
                     state_d = StDone;
                  end
                  // CE is raised on the same edge that re-enters FETCH.
                  if (state_d == StFetch) begin
                     ce_d   = 1'b1;
                     addr_d = idx_d;
                     lat_d  = '0;
                  end
               end else begin
                  hold_d = hold_q + 16'd1;
               end
            end

            StDone: begin
               if (!start_q) begin
                  state_d = StIdle;
               end
            end

            default: state_d = StIdle;
         endcase
      end
   end

   assign o_wf_ram_addr      = addr_q;
   assign o_wf_ram_ce        = ce_q;
   assign o_wf_sample        = sample_q;
   assign o_wf_sample_valid  = valid_q;
   assign o_dsp_wf_mode      = (state_q == StFetch) || (state_q == StHold);
   assign o_wf_done          = (state_q == StDone);
   assign o_wf_read_data_num = num_q;

endmodule

// File: tb/tb_wf_player.sv
// -----------------------------------------------------------------------------
// tb_wf_player -- directed self-checking bench for wf_player
//
// A behavioural DPBRAM with RAM[i] = 16'h100 + i feeds the player. Edge E0 is
// the first clock edge at which start is seen high. Outputs are sampled 1 time
// unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_wf_player;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 16;
   localparam int RD_LAT = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              loop_en = 1'b0;
   logic [31:0]       read_cnt = '0;
   logic [15:0]       period = '0;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_ce;
   logic [DATA_W-1:0] ram_dout = '0;
   logic [DATA_W-1:0] sample;
   logic              sample_valid;
   logic              wf_mode;
   logic              done;
   logic [31:0]       data_num;

   logic [DATA_W-1:0] mem [2**ADDR_W];

   int n_cmp = 0;
   int n_mis = 0;

   wf_player #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .RD_LAT(RD_LAT)
   ) dut (
      .i_clk              (clk),
      .i_rst              (rst_n),
      .i_wf_start         (start),
      .i_wf_abort         (abort),
      .i_wf_loop          (loop_en),
      .i_wf_read_cnt      (read_cnt),
      .i_wf_period        (period),
      .o_wf_ram_addr      (ram_addr),
      .o_wf_ram_ce        (ram_ce),
      .i_wf_ram_dout      (ram_dout),
      .o_wf_sample        (sample),
      .o_wf_sample_valid  (sample_valid),
      .o_dsp_wf_mode      (wf_mode),
      .o_wf_done          (done),
      .o_wf_read_data_num (data_num)
   );

   always #5 clk = ~clk;

   // CE/addr registered at edge Ec -> dout updated at Ec+1 -> captured at Ec+2.
   always @(posedge clk) begin
      if (ram_ce) ram_dout <= mem[ram_addr];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      while ((done || wf_mode) && k < 10) begin
         step();
         k++;
      end
      step();
      chk(tag, {30'd0, done, wf_mode}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int v [3];
      int nv;
      int done_cyc;
      int mode_bad;
      logic [15:0] samp [8];
      int nce;
      int last_addr;
      int k;

      for (int i = 0; i < 2**ADDR_W; i++) mem[i] = 16'(16'h100 + i);

      // Reset state
      step();
      step();
      chk("rst_ce", 32'(ram_ce), 32'd0);
      chk("rst_addr", 32'(ram_addr), 32'd0);
      chk("rst_valid", 32'(sample_valid), 32'd0);
      chk("rst_sample", 32'(sample), 32'd0);
      chk("rst_mode_done", {30'd0, wf_mode, done}, 32'd0);
      chk("rst_num", data_num, 32'd0);
      rst_n = 1'b1;
      step();

      // 1. Basic playback: CE at E1,E4,E7,E10, valid at E3,E6,E9,E12
      read_cnt = 32'd4;
      period   = 16'd0;
      start    = 1'b1;
      step();                                      // E0
      chk("t1_e0_ce", 32'(ram_ce), 32'd0);
      for (int s = 0; s < 4; s++) begin
         step();
         chk("t1_ce", 32'(ram_ce), 32'd1);
         chk("t1_addr", 32'(ram_addr), 32'(s));
         chk("t1_mode", 32'(wf_mode), 32'd1);
         step();
         chk("t1_ce_low", 32'(ram_ce), 32'd0);
         chk("t1_valid_early", 32'(sample_valid), 32'd0);
         step();
         chk("t1_valid", 32'(sample_valid), 32'd1);
         chk("t1_sample", 32'(sample), 32'(16'h100 + s));
         chk("t1_num", data_num, 32'(s + 1));
      end
      step();                                      // E13
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_mode_off", 32'(wf_mode), 32'd0);
      chk("t1_addr_zero", 32'(ram_addr), 32'd0);
      start = 1'b0;
      wait_idle("t1_idle");

      // 2. Hold period of 5: strobes 8 cycles apart, done at E25
      read_cnt = 32'd3;
      period   = 16'd5;
      start    = 1'b1;
      v        = '{-1, -1, -1};
      nv       = 0;
      done_cyc = -1;
      mode_bad = 0;
      step();                                      // E0
      for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
         step();
         if (sample_valid) begin
            if (nv < 3) v[nv] = c;
            nv++;
         end
         if (done) done_cyc = c;
         else if (!wf_mode) mode_bad++;
      end
      chk("t2_nvalid", 32'(nv), 32'd3);
      chk("t2_first", 32'(v[0]), 32'd3);
      chk("t2_gap1", 32'(v[1] - v[0]), 32'd8);
      chk("t2_gap2", 32'(v[2] - v[1]), 32'd8);
      chk("t2_done_cyc", 32'(done_cyc), 32'd25);
      chk("t2_mode_bad", 32'(mode_bad), 32'd0);
      chk("t2_last", 32'(sample), 32'h102);
      start = 1'b0;
      wait_idle("t2_idle");

      // 3. Loop: 100,101,100,101,100 then loop cleared -> 101 then DONE
      read_cnt = 32'd2;
      period   = 16'd0;
      loop_en  = 1'b1;
      start    = 1'b1;
      nv       = 0;
      samp     = '{default: '0};
      step();
      k = 0;
      while (!done && k < 60) begin
         step();
         k++;
         if (sample_valid) begin
            if (nv < 8) samp[nv] = sample;
            nv++;
            if (nv == 5) loop_en = 1'b0;
         end
      end
      chk("t3_done", 32'(done), 32'd1);
      chk("t3_nvalid", 32'(nv), 32'd6);
      for (int s = 0; s < 6; s++) chk("t3_sample", 32'(samp[s]), 32'(16'h100 + (s % 2)));
      chk("t3_num", data_num, 32'd6);
      start = 1'b0;
      wait_idle("t3_idle");

      // 4. Abort with CE issued and read data pending
      read_cnt = 32'd4;
      start    = 1'b1;
      step();                                      // E0
      step();                                      // E1
      chk("t4_ce", 32'(ram_ce), 32'd1);
      abort = 1'b1;
      step();                                      // E2
      chk("t4_mode", 32'(wf_mode), 32'd0);
      chk("t4_ce_off", 32'(ram_ce), 32'd0);
      chk("t4_sample_kept", 32'(sample), 32'h101);
      chk("t4_num_kept", data_num, 32'd0);
      step();                                      // E3: data would have landed here
      chk("t4_no_valid", 32'(sample_valid), 32'd0);
      chk("t4_sample_still", 32'(sample), 32'h101);
      start = 1'b0;
      step();
      step();
      abort = 1'b0;
      step();
      chk("t4_still_idle", {30'd0, wf_mode, done}, 32'd0);
      start = 1'b1;
      step();                                      // E0
      step();                                      // E1
      chk("t4_replay_ce", 32'(ram_ce), 32'd1);
      chk("t4_replay_addr", 32'(ram_addr), 32'd0);
      step();
      step();                                      // E3
      chk("t4_replay_valid", 32'(sample_valid), 32'd1);
      chk("t4_replay_sample", 32'(sample), 32'h100);
      abort = 1'b1;
      start = 1'b0;
      step();
      step();
      abort = 1'b0;
      wait_idle("t4_idle");

      // 5a. cnt=0 goes straight to DONE; held start does not retrigger
      read_cnt = 32'd0;
      start    = 1'b1;
      step();                                      // E0
      step();                                      // E1
      chk("t5_zero_done", 32'(done), 32'd1);
      chk("t5_zero_mode", 32'(wf_mode), 32'd0);
      nce = 0;
      read_cnt = 32'd1;
      for (int c = 0; c < 6; c++) begin
         step();
         if (ram_ce || wf_mode) nce++;
      end
      chk("t5_no_retrigger", 32'(nce), 32'd0);
      chk("t5_done_held", 32'(done), 32'd1);
      start = 1'b0;
      wait_idle("t5_done_release");
      start = 1'b1;
      step();
      step();
      chk("t5_retrigger_ce", 32'(ram_ce), 32'd1);
      start = 1'b0;
      k = 0;
      while (!done && k < 20) begin
         step();
         k++;
      end
      wait_idle("t5_one_idle");

      // 5b. cnt=1000 clipped to 512 samples, last address 511
      read_cnt  = 32'd1000;
      start     = 1'b1;
      nce       = 0;
      nv        = 0;
      last_addr = -1;
      step();
      k = 0;
      while (!done && k < 2000) begin
         step();
         k++;
         if (ram_ce) begin
            nce++;
            last_addr = int'(ram_addr);
         end
         if (sample_valid) nv++;
      end
      chk("t5_clip_ce", 32'(nce), 32'd512);
      chk("t5_clip_last_addr", 32'(last_addr), 32'd511);
      chk("t5_clip_valid", 32'(nv), 32'd512);
      chk("t5_clip_num", data_num, 32'd512);
      chk("t5_clip_sample", 32'(sample), 32'h2FF);
      start = 1'b0;
      wait_idle("t5_clip_idle");

      // 6. Asynchronous reset during HOLD
      read_cnt = 32'd3;
      period   = 16'd5;
      start    = 1'b1;
      step();
      k = 0;
      while (!sample_valid && k < 10) begin
         step();
         k++;
      end
      chk("t6_first_valid", 32'(sample_valid), 32'd1);
      step();
      step();
      chk("t6_in_hold", 32'(wf_mode), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_sample", 32'(sample), 32'd0);
      chk("t6_rst_num", data_num, 32'd0);
      chk("t6_rst_flags", {28'd0, wf_mode, done, sample_valid, ram_ce}, 32'd0);
      start = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      step();
      chk("t6_idle_after", {30'd0, wf_mode, done}, 32'd0);
      chk("t6_ce_after", 32'(ram_ce), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
